exe_muldiv: RTL

- Execute-stage iterative multiply/divide unit with architectural HI/LO registers.
- Consumes the decode/execute pipeline register outputs: the rs operand value, the rt operand value, and the decoded mul/div control.
- Drives busy to the hazard unit, which stalls fetch/decode while an operation is in flight.
- HI/LO are read by the MFHI/MFLO path in the same stage.

---
 rtl/exe_muldiv_if.sv | 25 ++
 rtl/exe_muldiv.sv | 137 +++++++++++++
 2 files changed

// File: rtl/exe_muldiv_if.sv
// Execute-stage mul/div bundle: operands and control from decode/execute,
// HI/LO plus busy/done back to the execute stage and hazard unit.
interface exe_muldiv_if #(parameter int WIDTH = 32);
  logic             clear;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output clear, start, op, a, b, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  clear, start, op, a, b, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One shift-add / restoring-divide step per cycle, then a sign-fix cycle.
//
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo writes accepted
// CALC   | WIDTH iteration steps, counter counts down to 0
// FIX    | sign correction and HI/LO write, done pulses next cycle
module exe_muldiv #(
  parameter int WIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  exe_muldiv_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             div0;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lwr;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc} + (lwr[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    div_sh    = {acc, lwr[WIDTH-1]};
    div_trial = div_sh - {1'b0, opb};
    prod_fix  = neg_q ? -{acc, lwr} : {acc, lwr};
    // A zero divisor leaves the dividend in acc; re-applying its sign restores a exactly.
    quo_fix   = div0 ? {WIDTH{1'b1}} : (neg_q ? -lwr : lwr);
    rem_fix   = neg_r ? -acc : acc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
      acc    <= '0;
      lwr    <= '0;
      opb    <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mthi) hi_r <= bus.a;
          if (bus.mtlo) lo_r <= bus.a;
          if (bus.start && !bus.clear) begin
            state  <= S_CALC;
            busy_r <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            is_div <= bus.op[1];
            neg_q  <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r  <= signed_op && bus.a[WIDTH-1];
            div0   <= bus.op[1] && (bus.b == '0);
            acc    <= '0;
            // Multiply keeps the multiplier in lwr; divide keeps the dividend there.
            lwr    <= bus.op[1] ? a_abs : b_abs;
            opb    <= bus.op[1] ? b_abs : a_abs;
          end
        end
        S_CALC: begin
          if (bus.clear) begin
            state  <= S_IDLE;
            busy_r <= 1'b0;
          end else begin
            if (!is_div) begin
              {acc, lwr} <= {mul_sum, lwr[WIDTH-1:1]};
            end else if (!div_trial[WIDTH]) begin
              acc <= div_trial[WIDTH-1:0];
              lwr <= {lwr[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_sh[WIDTH-1:0];
              lwr <= {lwr[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= S_FIX;
          end
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          if (!bus.clear) begin
            done_r <= 1'b1;
            if (is_div) begin
              hi_r <= rem_fix;
              lo_r <= quo_fix;
            end else begin
              hi_r <= prod_fix[2*WIDTH-1:WIDTH];
              lo_r <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule
